// File: rtl/mux4_rr_arbiter.sv
// Four-input round-robin arbiter driving a registered 4:1 data mux.
// Each requester may hold the grant for HOLD_MAX cycles while others wait; a lone requester keeps it indefinitely.
module mux4_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       o,
    output logic       o_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    state_t     state;
    state_t     nxt_state;
    logic [1:0] ptr;
    logic [1:0] nxt_ptr;
    logic [1:0] cur;
    logic [1:0] nxt_idx;
    logic [3:0] hold_cnt;
    logic [3:0] nxt_hold;
    logic [2:0] pick_all;
    logic [2:0] pick_oth;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] r;
        r      = 4'b0000;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Returns {found, index}; scanning from the farthest offset down lets the nearest hit to start win.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign cur      = {s1, s0};
    assign pick_all = rr_pick(req, ptr);
    assign pick_oth = rr_pick(req & ~onehot(cur), ptr);

    always_comb begin
        nxt_state = state;
        nxt_idx   = cur;
        nxt_hold  = hold_cnt;
        nxt_ptr   = ptr;
        case (state)
            IDLE: begin
                if (pick_all[2]) begin
                    nxt_state = GRANT;
                    nxt_idx   = pick_all[1:0];
                    nxt_hold  = 4'd1;
                    nxt_ptr   = pick_all[1:0] + 2'd1;
                end
            end
            GRANT: begin
                if (req[cur]) begin
                    if (hold_cnt < HOLD_LIM) begin
                        nxt_hold = hold_cnt + 4'd1;
                    end else if (pick_oth[2]) begin
                        nxt_idx  = pick_oth[1:0];
                        nxt_hold = 4'd1;
                        nxt_ptr  = pick_oth[1:0] + 2'd1;
                    end else begin
                        nxt_hold = 4'd1;
                    end
                end else if (pick_all[2]) begin
                    // Released grant hands over on the same edge, so there is no idle bubble.
                    nxt_idx  = pick_all[1:0];
                    nxt_hold = 4'd1;
                    nxt_ptr  = pick_all[1:0] + 2'd1;
                end else begin
                    nxt_state = IDLE;
                    nxt_hold  = 4'd0;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Select bits keep the last grantee while idle; only gnt is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            s1       <= 1'b0;
            s0       <= 1'b0;
            o        <= 1'b0;
            o_valid  <= 1'b0;
            busy     <= 1'b0;
            ptr      <= 2'd0;
            hold_cnt <= 4'd0;
        end else begin
            state    <= nxt_state;
            hold_cnt <= nxt_hold;
            ptr      <= nxt_ptr;
            s1       <= nxt_idx[1];
            s0       <= nxt_idx[0];
            gnt      <= (nxt_state == GRANT) ? onehot(nxt_idx) : 4'b0000;
            busy     <= (nxt_state == GRANT);
            o_valid  <= (state == GRANT) && req[cur];
            if ((state == GRANT) && req[cur]) begin
                o <= din[cur];
            end
        end
    end

endmodule
